// File: rtl/dcache_pkg.sv
// Shared state encoding, default widths and address-split helpers for the data cache.
package dcache_pkg;

  localparam int DCACHE_DATA_W = 32;
  localparam int DCACHE_ADDR_W = 32;
  localparam int DCACHE_IDX_W  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    DONE    = 2'd3
  } dc_state_e;

  function automatic int lines(input int idx_w);
    return 1 << idx_w;
  endfunction

  // Two byte-offset bits sit below the index.
  function automatic int tag_w(input int addr_w, input int idx_w);
    return addr_w - idx_w - 2;
  endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// CPU MEM-stage and backing-memory signal bundle; slave is the cache, master is the CPU/memory side.
interface dcache_ctrl_if import dcache_pkg::*; #(
  parameter int DATA_W = DCACHE_DATA_W,
  parameter int ADDR_W = DCACHE_ADDR_W
) ();

  logic              cpu_req_i;
  logic              cpu_we_i;
  logic [ADDR_W-1:0] cpu_addr_i;
  logic [DATA_W-1:0] cpu_wdata_i;
  logic [DATA_W-1:0] cpu_rdata_o;
  logic              cpu_stall_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_ack_i;

  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, mem_rdata_i, mem_ack_i,
    output cpu_rdata_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, mem_rdata_i, mem_ack_i,
    input  cpu_rdata_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

endinterface

// File: rtl/dcache_tag_array.sv
// Valid/tag/data line storage: combinational read by index, synchronous write, synchronous valid clear.
// Only the valid bits are cleared; tag and data contents survive reset.
module dcache_tag_array import dcache_pkg::*; #(
  parameter int DATA_W = DCACHE_DATA_W,
  parameter int TAG_W  = 26,
  parameter int IDX_W  = DCACHE_IDX_W
) (
  input  logic              clk_i,
  input  logic              clr_i,
  input  logic [IDX_W-1:0]  idx_i,
  output logic              rd_vld_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [DATA_W-1:0] rd_dat_o,
  input  logic              wr_en_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [DATA_W-1:0] wr_dat_i
);

  localparam int LINES = lines(IDX_W);

  logic [LINES-1:0]  vld_q;
  logic [TAG_W-1:0]  tag_q [LINES];
  logic [DATA_W-1:0] dat_q [LINES];

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      vld_q <= '0;
    end else if (wr_en_i) begin
      vld_q[idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      tag_q[idx_i] <= wr_tag_i;
      dat_q[idx_i] <= wr_dat_i;
    end
  end

  assign rd_vld_o = vld_q[idx_i];
  assign rd_tag_o = tag_q[idx_i];
  assign rd_dat_o = dat_q[idx_i];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache between the CPU MEM stage and memory.
// Define DCACHE_STATS_EN to add saturating hit_cnt_o / miss_cnt_o counters.
module dcache_ctrl import dcache_pkg::*; #(
  parameter int DATA_W = DCACHE_DATA_W,
  parameter int ADDR_W = DCACHE_ADDR_W,
  parameter int IDX_W  = DCACHE_IDX_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  dcache_ctrl_if.slave bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  hit_cnt_o,
  output logic [31:0]  miss_cnt_o
`endif
);

  localparam int TAG_W = tag_w(ADDR_W, IDX_W);

  dc_state_e         state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [ADDR_W-1:0] word_addr;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag, line_tag;
  logic              line_vld, hit;
  logic [DATA_W-1:0] line_dat, wr_dat, cpu_rdata;
  logic              wr_en, stall;

  assign word_addr = bus.cpu_addr_i & ~ADDR_W'(3);
  // While waiting, look up the registered request so the refill/update hits the line that started it.
  assign idx = (state_q == IDLE) ? word_addr[IDX_W+1:2] : mem_addr_q[IDX_W+1:2];
  assign tag = (state_q == IDLE) ? word_addr[ADDR_W-1:IDX_W+2] : mem_addr_q[ADDR_W-1:IDX_W+2];
  assign hit = line_vld && (line_tag == tag);

  dcache_tag_array #(
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W),
    .IDX_W  (IDX_W)
  ) u_lines (
    .clk_i    (clk_i),
    .clr_i    (!rst_i),
    .idx_i    (idx),
    .rd_vld_o (line_vld),
    .rd_tag_o (line_tag),
    .rd_dat_o (line_dat),
    .wr_en_i  (wr_en),
    .wr_tag_i (tag),
    .wr_dat_i (wr_dat)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    wr_en       = 1'b0;
    wr_dat      = bus.mem_rdata_i;
    stall       = 1'b0;
    cpu_rdata   = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cpu_req_i) begin
          if (!bus.cpu_we_i && hit) begin
            cpu_rdata = line_dat;
          end else begin
            stall       = 1'b1;
            state_d     = bus.cpu_we_i ? WR_WAIT : RD_WAIT;
            mem_req_d   = 1'b1;
            mem_we_d    = bus.cpu_we_i;
            mem_addr_d  = word_addr;
            mem_wdata_d = bus.cpu_wdata_i;
          end
        end
      end
      RD_WAIT: begin
        stall = 1'b1;
        if (bus.mem_ack_i) begin
          wr_en     = 1'b1;
          rdata_d   = bus.mem_rdata_i;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = DONE;
        end
      end
      WR_WAIT: begin
        stall = 1'b1;
        if (bus.mem_ack_i) begin
          wr_en     = hit;
          wr_dat    = mem_wdata_q;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.cpu_stall_o = stall;
  assign bus.cpu_rdata_o = cpu_rdata;
  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;

`ifdef DCACHE_STATS_EN
  logic        hit_evt, miss_evt;
  logic [31:0] hit_cnt_q, miss_cnt_q;

  assign hit_evt  = (state_q == IDLE) && bus.cpu_req_i && !bus.cpu_we_i && hit;
  assign miss_evt = (state_q == IDLE) && bus.cpu_req_i && !bus.cpu_we_i && !hit;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_evt && (hit_cnt_q != '1)) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (miss_evt && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

  // The CPU must hold its request for the whole stall; dropping it is a pipeline bug upstream.
  assert property (@(posedge clk_i) disable iff (!rst_i) bus.cpu_stall_o |-> bus.cpu_req_i);

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed vector table, reset-abort sequence, randomized traffic
// against a transaction-level cache/memory model, and (with DCACHE_STATS_EN) counter checks.
module tb_dcache_ctrl;
  import dcache_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dcache_ctrl_if #(.DATA_W(32), .ADDR_W(32)) bus ();

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  dcache_ctrl #(.DATA_W(32), .ADDR_W(32), .IDX_W(4)) dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .bus        (bus.slave)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt_o  (hit_cnt),
    .miss_cnt_o (miss_cnt)
`endif
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } memtx_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    int          exp_stalls;
    logic [31:0] exp_rdata;
    int          exp_tx;
    logic [31:0] exp_maddr;
  } vec_t;

  memtx_t      txq[$];
  logic [31:0] bmem    [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] ref_line[int];

  int          ack_lat  = 0;
  bit          resp_en  = 1'b1;
  int          wait_cnt = 0;
  logic        resp_ack = 1'b0;
  logic        man_ack  = 1'b0;
  logic [31:0] resp_rdata = '0;
  logic [31:0] man_rdata  = '0;

  int n_chk  = 0;
  int n_fail = 0;

  assign bus.mem_ack_i   = resp_ack | man_ack;
  assign bus.mem_rdata_i = man_ack ? man_rdata : resp_rdata;

  function automatic logic [31:0] mem_init(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] bmem_rd(input logic [31:0] a);
    return bmem.exists(a) ? bmem[a] : mem_init(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
  endfunction

  // Backing memory: acks ack_lat cycles after the request is first seen.
  always @(negedge clk) begin
    resp_ack = 1'b0;
    if (resp_en && rst_n && bus.mem_req_o) begin
      if (wait_cnt >= ack_lat) begin
        resp_ack = 1'b1;
        wait_cnt = 0;
        txq.push_back('{bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o});
        if (bus.mem_we_o) bmem[bus.mem_addr_o] = bus.mem_wdata_o;
        else resp_rdata = bmem_rd(bus.mem_addr_o);
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int lat, output logic [31:0] rdata, output int stalls);
    @(negedge clk);
    ack_lat = lat;
    txq.delete();
    bus.cpu_req_i   = 1'b1;
    bus.cpu_we_i    = we;
    bus.cpu_addr_i  = addr;
    bus.cpu_wdata_i = wdata;
    #1;
    stalls = 0;
    while (bus.cpu_stall_o === 1'b1 && stalls < 40) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    rdata = bus.cpu_rdata_o;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus.cpu_req_i = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.cpu_req_i = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_tx(input string name, input int exp_n, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata);
    check({name, " txcount"}, 32'(txq.size()), 32'(exp_n));
    if (exp_n > 0 && txq.size() > 0) begin
      check({name, " mem_we"}, 32'(txq[0].we), 32'(we));
      check({name, " mem_addr"}, txq[0].addr, addr);
      if (we) check({name, " mem_wdata"}, txq[0].wdata, wdata);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[$];
    logic [31:0] rd;
    int          st;

    bus.cpu_req_i   = 1'b0;
    bus.cpu_we_i    = 1'b0;
    bus.cpu_addr_i  = '0;
    bus.cpu_wdata_i = '0;

    foreach (vecs[i]) vecs.delete(i);
    vecs.push_back('{1'b0, 32'h40,  32'h0,        2, 4, 32'hDEADBEEF, 1, 32'h40});
    vecs.push_back('{1'b0, 32'h40,  32'h0,        2, 0, 32'hDEADBEEF, 0, 32'h0});
    vecs.push_back('{1'b0, 32'h80,  32'h0,        0, 2, 32'hCAFEF00D, 1, 32'h80});
    vecs.push_back('{1'b0, 32'h40,  32'h0,        1, 3, 32'hDEADBEEF, 1, 32'h40});
    vecs.push_back('{1'b1, 32'h40,  32'h12345678, 1, 3, 32'h0,        1, 32'h40});
    vecs.push_back('{1'b0, 32'h40,  32'h0,        1, 0, 32'h12345678, 0, 32'h0});
    vecs.push_back('{1'b1, 32'h100, 32'hA5A50001, 0, 2, 32'h0,        1, 32'h100});
    vecs.push_back('{1'b0, 32'h100, 32'h0,        0, 2, 32'hA5A50001, 1, 32'h100});
    vecs.push_back('{1'b0, 32'h40,  32'h0,        0, 2, 32'h12345678, 1, 32'h40});
    vecs.push_back('{1'b0, 32'h43,  32'h0,        0, 0, 32'h12345678, 0, 32'h0});
    vecs.push_back('{1'b0, 32'h44,  32'h0,        3, 5, 32'h44444444, 1, 32'h44});
    vecs.push_back('{1'b1, 32'h47,  32'h00000055, 0, 2, 32'h0,        1, 32'h44});
    vecs.push_back('{1'b0, 32'h46,  32'h0,        0, 0, 32'h00000055, 0, 32'h0});

    bmem[32'h40] = 32'hDEADBEEF; ref_mem[32'h40] = 32'hDEADBEEF;
    bmem[32'h80] = 32'hCAFEF00D; ref_mem[32'h80] = 32'hCAFEF00D;
    bmem[32'h44] = 32'h44444444; ref_mem[32'h44] = 32'h44444444;

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset stall", 32'(bus.cpu_stall_o), 32'h0);
    check("reset rdata", bus.cpu_rdata_o, 32'h0);
    check("reset mem_req", 32'(bus.mem_req_o), 32'h0);
    check("reset mem_we", 32'(bus.mem_we_o), 32'h0);
    check("reset mem_addr", bus.mem_addr_o, 32'h0);
    check("reset mem_wdata", bus.mem_wdata_o, 32'h0);

    // Directed vectors
    for (int i = 0; i < vecs.size(); i++) begin
      access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].lat, rd, st);
      check($sformatf("vec%0d stalls", i), 32'(st), 32'(vecs[i].exp_stalls));
      if (!vecs[i].we) check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
      check_tx($sformatf("vec%0d", i), vecs[i].exp_tx, vecs[i].we, vecs[i].exp_maddr, vecs[i].wdata);
      if (vecs[i].we) ref_mem[vecs[i].addr & ~32'h3] = vecs[i].wdata;
    end
    idle(1);

    // Reset while a refill is outstanding, then a late ack
    resp_en = 1'b0;
    bus.cpu_req_i  = 1'b1;
    bus.cpu_we_i   = 1'b0;
    bus.cpu_addr_i = 32'hC0;
    @(negedge clk); #1;
    check("rstwait mem_req", 32'(bus.mem_req_o), 32'h1);
    check("rstwait mem_addr", bus.mem_addr_o, 32'hC0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.cpu_req_i = 1'b0;
    man_ack   = 1'b1;
    man_rdata = 32'h0BAD0BAD;
    @(negedge clk);
    man_ack = 1'b0;
    #1;
    check("rstwait mem_req after", 32'(bus.mem_req_o), 32'h0);
    check("rstwait mem_we after", 32'(bus.mem_we_o), 32'h0);
    check("rstwait stall after", 32'(bus.cpu_stall_o), 32'h0);
    check("rstwait state", 32'(dut.state_q), 32'(IDLE));
    resp_en = 1'b1;
    access(1'b0, 32'hC0, 32'h0, 1, rd, st);
    check("rstwait reread stalls", 32'(st), 32'd3);
    check("rstwait reread rdata", rd, ref_rd(32'hC0));
    check_tx("rstwait reread", 1, 1'b0, 32'hC0, 32'h0);
    access(1'b0, 32'h44, 32'h0, 0, rd, st);
    check("rstwait cold 0x44 stalls", 32'(st), 32'd2);
    check("rstwait cold 0x44 rdata", rd, 32'h00000055);
    idle(1);

    // Randomized traffic against a transaction-level model
    do_reset();
    ref_line.delete();
    for (int i = 0; i < 300; i++) begin
      logic        we;
      logic [31:0] addr, word, wd;
      int          lat, ix;
      bit          hit;
      we   = ($urandom_range(0, 9) < 3);
      word = 32'h2000 | (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 3)) << 2);
      addr = word | 32'($urandom_range(0, 3));
      wd   = $urandom();
      lat  = $urandom_range(0, 3);
      ix   = int'(word[5:2]);
      hit  = ref_line.exists(ix) && (ref_line[ix] == word);
      access(we, addr, wd, lat, rd, st);
      if (we) begin
        check($sformatf("rnd%0d wr stalls", i), 32'(st), 32'(lat + 2));
        check_tx($sformatf("rnd%0d wr", i), 1, 1'b1, word, wd);
        ref_mem[word] = wd;
      end else begin
        check($sformatf("rnd%0d rd stalls", i), 32'(st), hit ? 32'd0 : 32'(lat + 2));
        check($sformatf("rnd%0d rd rdata", i), rd, ref_rd(word));
        check_tx($sformatf("rnd%0d rd", i), hit ? 0 : 1, 1'b0, word, 32'h0);
        ref_line[ix] = word;
      end
    end
    idle(1);

`ifdef DCACHE_STATS_EN
    do_reset();
    #1;
    check("stats reset hit", hit_cnt, 32'd0);
    check("stats reset miss", miss_cnt, 32'd0);
    access(1'b0, 32'h40, 32'h0, 0, rd, st);
    access(1'b0, 32'h40, 32'h0, 0, rd, st);
    access(1'b0, 32'h40, 32'h0, 0, rd, st);
    access(1'b0, 32'h80, 32'h0, 1, rd, st);
    access(1'b0, 32'h80, 32'h0, 0, rd, st);
    access(1'b1, 32'h80, 32'h1, 0, rd, st);
    idle(1);
    #1;
    check("stats hit count", hit_cnt, 32'd3);
    check("stats miss count", miss_cnt, 32'd2);
    @(negedge clk);
    force dut.hit_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.hit_cnt_q;
    access(1'b0, 32'h80, 32'h0, 0, rd, st);
    idle(1);
    #1;
    check("stats hit saturate", hit_cnt, 32'hFFFF_FFFF);
    check("stats miss after sat", miss_cnt, 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
